// File: rtl/alu_cmd_issue_pkg.sv
// Shared constants for the ALU command issue block: opcode map and result-register FSM encoding.
package alu_cmd_issue_pkg;

    // Opcode bits map onto the ALU select lines as {i1, i2, i3}
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    localparam logic [0:0] RES_EMPTY = 1'b0;
    localparam logic [0:0] RES_FULL  = 1'b1;

endpackage

// File: rtl/alu_cmd_issue_if.sv
// Command and result handshake bundle between the issue block and its upstream/downstream.
interface alu_cmd_issue_if #(
    parameter int N = 9
) ();

    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;

    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic [2:0]   res_op;

    // master: the environment issuing commands and consuming results
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_op
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_op
    );

endinterface

// File: rtl/cmd_fifo.sv
// Command FIFO: storage, wrapping pointers and occupancy; head reads as zero when empty.
module cmd_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/alu_cmd_issue.sv
// Queues ALU commands, presents the head to an external ALU and registers each result in order.
module alu_cmd_issue
    import alu_cmd_issue_pkg::*;
#(
    parameter int N     = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_cmd_issue_if.slave         bus,
    output logic [N-1:0]           alu_a,
    output logic [N-1:0]           alu_b,
    output logic                   alu_i1,
    output logic                   alu_i2,
    output logic                   alu_i3,
    input  logic [N-1:0]           alu_y,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             issued_cnt
);

    localparam int W  = 2 * N + 3;
    localparam int CW = $clog2(DEPTH) + 1;

    logic         push;
    logic         pop;
    logic         fifo_empty;
    logic [W-1:0] head;
    logic [2:0]   head_op;

    logic [0:0]   state_q, state_d;
    logic [N-1:0] res_data_q, res_data_d;
    logic [2:0]   res_op_q, res_op_d;
    logic [7:0]   issued_q, issued_d;

    cmd_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Ready depends only on occupancy, never on a same-cycle pop
    assign bus.cmd_ready = (fifo_count < CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = !fifo_empty && ((state_q == RES_EMPTY) || bus.res_ready);

    assign head_op = head[W-1 -: 3];
    assign alu_a   = head[2*N-1 -: N];
    assign alu_b   = head[N-1:0];
    assign alu_i1  = head_op[2];
    assign alu_i2  = head_op[1];
    assign alu_i3  = head_op[0];

    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
        issued_d   = issued_q;
        if (pop) begin
            state_d    = RES_FULL;
            res_data_d = alu_y;
            res_op_d   = head_op;
            issued_d   = issued_q + 8'd1;
        end else if ((state_q == RES_FULL) && bus.res_ready) begin
            state_d = RES_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RES_EMPTY;
            res_data_q <= '0;
            res_op_q   <= '0;
            issued_q   <= '0;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_op_q   <= res_op_d;
            issued_q   <= issued_d;
        end
    end

    assign bus.res_valid = (state_q == RES_FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;
    assign issued_cnt    = issued_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a behavioural 8-function ALU attached.
module tb_alu_cmd_issue;
    import alu_cmd_issue_pkg::*;

    localparam int N     = 9;
    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] y;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] alu_a, alu_b, alu_y;
    logic         alu_i1, alu_i2, alu_i3;
    logic [2:0]   fifo_count;
    logic [7:0]   issued_cnt;

    int n_cmp = 0;
    int n_err = 0;

    vec_t         vecs [10];
    logic [N-1:0] exp_seq [6];

    alu_cmd_issue_if #(.N(N)) bus ();

    alu_cmd_issue #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_i1     (alu_i1),
        .alu_i2     (alu_i2),
        .alu_i3     (alu_i3),
        .alu_y      (alu_y),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    // The external ALU
    always_comb begin
        alu_y = '0;
        case ({alu_i1, alu_i2, alu_i3})
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_NAND: alu_y = ~(alu_a & alu_b);
            OP_NOR:  alu_y = ~(alu_a | alu_b);
            OP_XOR:  alu_y = alu_a ^ alu_b;
            OP_XNOR: alu_y = ~(alu_a ^ alu_b);
            OP_SHL:  alu_y = {alu_a[N-2:0], 1'b0};
            OP_SHR:  alu_y = {1'b0, alu_a[N-1:1]};
            default: alu_y = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " res_valid"}, 32'(bus.res_valid), 0);
        check({tag, " res_data"}, 32'(bus.res_data), 0);
        check({tag, " res_op"}, 32'(bus.res_op), 0);
        check({tag, " fifo_count"}, 32'(fifo_count), 0);
        check({tag, " issued_cnt"}, 32'(issued_cnt), 0);
        check({tag, " alu_a/b"}, 32'({alu_a, alu_b}), 0);
        check({tag, " alu_sel"}, 32'({alu_i1, alu_i2, alu_i3}), 0);
        check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int guard;
        int exp_issued;
        logic seen;

        vecs[0] = '{op: OP_AND,  a: 9'h1F0, b: 9'h0FF, y: 9'h0F0};
        vecs[1] = '{op: OP_OR,   a: 9'h1F0, b: 9'h0FF, y: 9'h1FF};
        vecs[2] = '{op: OP_NAND, a: 9'h1F0, b: 9'h0FF, y: 9'h10F};
        vecs[3] = '{op: OP_NOR,  a: 9'h0A5, b: 9'h10A, y: 9'h050};
        vecs[4] = '{op: OP_XOR,  a: 9'h155, b: 9'h0FF, y: 9'h1AA};
        vecs[5] = '{op: OP_XNOR, a: 9'h155, b: 9'h0FF, y: 9'h055};
        vecs[6] = '{op: OP_SHL,  a: 9'h181, b: 9'h000, y: 9'h102};
        vecs[7] = '{op: OP_SHR,  a: 9'h181, b: 9'h000, y: 9'h0C0};
        vecs[8] = '{op: OP_SHL,  a: 9'h0FF, b: 9'h1FF, y: 9'h1FE};
        vecs[9] = '{op: OP_SHR,  a: 9'h001, b: 9'h1FF, y: 9'h000};
        // OR of (1 << k) with 9'h100
        exp_seq[0] = 9'h101; exp_seq[1] = 9'h102; exp_seq[2] = 9'h104;
        exp_seq[3] = 9'h108; exp_seq[4] = 9'h110; exp_seq[5] = 9'h120;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b1;
        exp_issued    = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Single commands, one at a time
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            bus.cmd_valid = 1'b0;
            check($sformatf("v%0d alu_a", i), 32'(alu_a), 32'(vecs[i].a));
            check($sformatf("v%0d alu_b", i), 32'(alu_b), 32'(vecs[i].b));
            check($sformatf("v%0d alu_sel", i), 32'({alu_i1, alu_i2, alu_i3}), 32'(vecs[i].op));
            check($sformatf("v%0d res_valid early", i), 32'(bus.res_valid), 0);
            step();
            exp_issued++;
            check($sformatf("v%0d res_valid", i), 32'(bus.res_valid), 1);
            check($sformatf("v%0d res_data", i), 32'(bus.res_data), 32'(vecs[i].y));
            check($sformatf("v%0d res_op", i), 32'(bus.res_op), 32'(vecs[i].op));
            check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 0);
            check($sformatf("v%0d issued_cnt", i), 32'(issued_cnt), 32'(exp_issued));
            step();
            check($sformatf("v%0d res_valid drop", i), 32'(bus.res_valid), 0);
        end

        // Back-to-back shifts: results on consecutive cycles
        drive(OP_SHL, 9'h181, 9'h000);
        step();
        drive(OP_SHR, 9'h181, 9'h000);
        step();
        bus.cmd_valid = 1'b0;
        check("b2b res_data0", 32'(bus.res_data), 32'h102);
        check("b2b res_op0", 32'(bus.res_op), 32'(OP_SHL));
        check("b2b fifo_count", 32'(fifo_count), 1);
        step();
        check("b2b res_valid1", 32'(bus.res_valid), 1);
        check("b2b res_data1", 32'(bus.res_data), 32'h0C0);
        check("b2b res_op1", 32'(bus.res_op), 32'(OP_SHR));
        step();
        exp_issued += 2;
        check("b2b idle", 32'(bus.res_valid), 0);

        // Backpressure: six offered, five accepted
        bus.res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive(OP_OR, 9'(1) << acc, 9'h100);
            seen = bus.cmd_ready;
            step();
            if (seen) acc++;
        end
        check("bp accepted", 32'(acc), 5);
        check("bp fifo_count full", 32'(fifo_count), 4);
        check("bp cmd_ready full", 32'(bus.cmd_ready), 0);
        check("bp res_valid", 32'(bus.res_valid), 1);
        check("bp res_data0", 32'(bus.res_data), 32'(exp_seq[0]));

        // Full FIFO with res_ready: no accept this cycle, accepted next
        drive(OP_OR, 9'h020, 9'h100);
        bus.res_ready = 1'b1;
        check("full cmd_ready same cycle", 32'(bus.cmd_ready), 0);
        step();
        check("full count 4->3", 32'(fifo_count), 3);
        check("full cmd_ready freed", 32'(bus.cmd_ready), 1);
        check("full res_data1", 32'(bus.res_data), 32'(exp_seq[1]));
        bus.res_ready = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        check("full count 3->4", 32'(fifo_count), 4);
        check("full hold res_data", 32'(bus.res_data), 32'(exp_seq[1]));
        bus.res_ready = 1'b1;
        for (int k = 2; k < 6; k++) begin
            step();
            check($sformatf("drain%0d res_valid", k), 32'(bus.res_valid), 1);
            check($sformatf("drain%0d res_data", k), 32'(bus.res_data), 32'(exp_seq[k]));
        end
        step();
        exp_issued += 6;
        check("drain done res_valid", 32'(bus.res_valid), 0);
        check("drain done fifo_count", 32'(fifo_count), 0);
        check("drain issued_cnt", 32'(issued_cnt), 32'(exp_issued));

        // Reset mid-operation: three queued plus a pending result
        bus.res_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(OP_XOR, 9'(c + 1), 9'h1FF);
            step();
        end
        bus.cmd_valid = 1'b0;
        check("prerst fifo_count", 32'(fifo_count), 3);
        check("prerst res_valid", 32'(bus.res_valid), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("postrst%0d res_valid", c), 32'(bus.res_valid), 0);
        end
        check("postrst issued_cnt", 32'(issued_cnt), 0);

        // 256 results wrap issued_cnt to zero
        drive(OP_AND, 9'h1FF, 9'h0AA);
        acc = 0;
        guard = 0;
        while (acc < 256 && guard < 400) begin
            seen = bus.cmd_ready;
            step();
            if (seen) acc++;
            guard++;
        end
        bus.cmd_valid = 1'b0;
        check("wrap accepted", 32'(acc), 256);
        guard = 0;
        while (bus.res_valid && guard < 10) begin
            step();
            guard++;
        end
        check("wrap drained", 32'(bus.res_valid), 0);
        check("wrap issued_cnt", 32'(issued_cnt), 0);
        check("wrap res_data", 32'(bus.res_data), 32'h0AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issue.md
ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

Interface
REQ-001 Parameter N, default 9: operand and result width, matching the 8-function logic/shift ALU it drives.
REQ-002 Parameter DEPTH, default 4: command FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 cmd_op  input  3  opcode; bit2->i1, bit1->i2, bit0->i3 of the ALU select.
REQ-008 cmd_a, cmd_b  input  N each  operands.
REQ-009 alu_a, alu_b  output  N each  operands to the ALU.
REQ-010 alu_i1, alu_i2, alu_i3  output  1 each  ALU select lines.
REQ-011 alu_y  input  N  combinational ALU result.
REQ-012 res_valid  output  1  result register holds a result.
REQ-013 res_ready  input  1  downstream accepts the result.
REQ-014 res_data  output  N  captured result; res_op  output  3  its opcode.
REQ-015 fifo_count  output  clog2(DEPTH)+1  FIFO occupancy; issued_cnt  output  8  results produced.

Function
REQ-016 Push occurs when cmd_valid && cmd_ready; cmd_ready = (fifo_count < DEPTH), independent of same-cycle pop.
REQ-017 FIFO head drives alu_a, alu_b, {alu_i1,alu_i2,alu_i3} directly from storage; when empty these are all zero.
REQ-018 Opcode map (for bench): 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 shift left by 1 of a (zero fill), 111 shift right by 1 of a (zero fill).
REQ-019 Result FSM has two states: RES_EMPTY (res_valid=0) and RES_FULL (res_valid=1).
REQ-020 Pop condition: fifo non-empty && (state==RES_EMPTY || res_ready).
REQ-021 On pop: res_data<=alu_y, res_op<=head opcode, state<=RES_FULL, issued_cnt increments.
REQ-022 RES_FULL && res_ready && FIFO empty -> RES_EMPTY; RES_FULL && !res_ready -> hold res_data/res_op stable.
REQ-023 Latency: command accepted at edge t appears on ALU ports after t, result registered at edge t+1 if result register free; back-to-back throughput one result per cycle under continuous res_ready.
REQ-024 Simultaneous push and pop: occupancy unchanged, order preserved, both pointers advance.
REQ-025 Pointers wrap modulo DEPTH; issued_cnt wraps 255->0 without flag.
REQ-026 Commands leave strictly in arrival order; no command dropped or duplicated.

Reset
REQ-027 rst_n low immediately clears: pointers, fifo_count=0, state=RES_EMPTY, res_valid=0, res_data=0, res_op=0, issued_cnt=0, ALU port outputs=0, cmd_ready=1 after release.
REQ-028 Reset asserted mid-operation discards all queued commands and any pending result; no result emitted afterwards for them.
REQ-029 FIFO storage contents need not be reset.

Structure
REQ-030 Shared package holds opcode constants (OP_AND..OP_SHR) and the FSM state encoding.
REQ-031 One sub-module, cmd_fifo (parameterised width 2N+3, DEPTH), holding storage, pointers and count; FSM and result register live in alu_cmd_issue.
REQ-032 ALU itself is instantiated outside; this block only connects via alu_* ports.

Verification (N=9, DEPTH=4, ALU connected)
REQ-033 op=000, a=9'h1F0, b=9'h0FF, res_ready=1 -> res_valid next edge after accept, res_data=9'h0F0, res_op=000.
REQ-034 op=110 then op=111, a=9'h181 back-to-back -> res_data 9'h102 then 9'h0C0 on consecutive cycles.
REQ-035 res_ready=0, drive 6 commands -> 5 accepted (1 in result reg, 4 in FIFO), cmd_ready=0, fifo_count=4; release res_ready -> 5 results in order.
REQ-036 FIFO full with res_ready=1 and cmd_valid=1 -> cmd_ready stays 0 that cycle, accepted next cycle; count 4->3->4.
REQ-037 Reset pulse with 3 queued and res_valid=1 -> all outputs zero within same cycle, no stale result after release.
REQ-038 256 results -> issued_cnt returns to 0.
